// File: rtl/sync_2ph_responder.sv
// sync_2ph_responder: clocked passive end of a two-phase bundled-data
// req/ack channel. It synchronizes req, captures the bundled payload,
// presents it on a valid/ready port, and toggles ack once the consumer has
// taken the payload and ACK_DELAY further cycles have passed.
module sync_2ph_responder #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_DELAY   = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req,
  input  logic [DATA_W-1:0] data,
  output logic              ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [15:0]       evt_count,
  output logic              protocol_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DELAY   = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [SYNC_STAGES-1:0]  sync_reg;
  logic [SYNC_STAGES-1:0]  sync_next;
  logic                    req_s;
  logic                    req_s_d_reg;
  logic                    pending;
  logic                    ack_reg, ack_next;
  logic                    out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]       out_data_reg, out_data_next;
  logic                    busy_reg, busy_next;
  logic [15:0]             evt_reg, evt_next;
  logic                    err_reg, err_next;
  logic [7:0]              cnt_reg, cnt_next;

  // Each synchronizer stage takes the value of the stage before it; stage 0
  // samples the raw asynchronous req.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = req;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign req_s   = sync_reg[SYNC_STAGES-1];
  assign pending = req_s ^ ack_reg;

  // Next-state and output decode; a req_s edge seen while a payload is
  // outstanding means the initiator withdrew its request early.
  always_comb begin
    state_next     = state_reg;
    ack_next       = ack_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    evt_next       = evt_reg;
    err_next       = err_reg;
    cnt_next       = cnt_reg;

    if ((state_reg == PRESENT || state_reg == DELAY) && (req_s != req_s_d_reg)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      IDLE: begin
        if (pending) begin
          out_data_next  = data;
          out_valid_next = 1'b1;
          state_next     = PRESENT;
        end
      end
      PRESENT: begin
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          if (ACK_DELAY == 0) begin
            ack_next   = ~ack_reg;
            evt_next   = evt_reg + 16'd1;
            state_next = IDLE;
          end else begin
            cnt_next   = 8'(ACK_DELAY);
            state_next = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt_reg == 8'd1) begin
          cnt_next   = 8'd0;
          ack_next   = ~ack_reg;
          evt_next   = evt_reg + 16'd1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and output registers; reset wins over any in-flight handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      sync_reg      <= '0;
      req_s_d_reg   <= 1'b0;
      ack_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      busy_reg      <= 1'b0;
      evt_reg       <= 16'd0;
      err_reg       <= 1'b0;
      cnt_reg       <= 8'd0;
    end else begin
      state_reg     <= state_next;
      sync_reg      <= sync_next;
      req_s_d_reg   <= req_s;
      ack_reg       <= ack_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      busy_reg      <= busy_next;
      evt_reg       <= evt_next;
      err_reg       <= err_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign ack          = ack_reg;
  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign busy         = busy_reg;
  assign evt_count    = evt_reg;
  assign protocol_err = err_reg;

endmodule
